// File: rtl/step_line_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | step_line_scheduler_if                                                   |
// | Move-command and stepper-driver bundle for step_line_scheduler.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface step_line_scheduler_if #(
  parameter int CNT_W = 32,
  parameter int PER_W = 32
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] dx;
  logic [CNT_W-1:0] dy;
  logic [PER_W-1:0] period;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             step_x;
  logic             step_y;
  logic             dir_x;
  logic             dir_y;
  logic [CNT_W-1:0] steps_left;
  logic [CNT_W-1:0] pos_x;
  logic [CNT_W-1:0] pos_y;

  modport master (
    output start, abort, dx, dy, period,
    input  busy, done, aborted, step_x, step_y, dir_x, dir_y,
           steps_left, pos_x, pos_y
  );

  modport slave (
    input  start, abort, dx, dy, period,
    output busy, done, aborted, step_x, step_y, dir_x, dir_y,
           steps_left, pos_x, pos_y
  );
endinterface
`default_nettype wire

// File: rtl/step_line_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | step_line_scheduler                                                      |
// | Two-axis Bresenham step-pulse scheduler; STEP_POS_TRACK_EN adds position.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module step_line_scheduler #(
  parameter int CNT_W        = 32,
  parameter int PER_W        = 32,
  parameter int PULSE_CYCLES = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  step_line_scheduler_if.slave bus
);

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_load  = 3'd1;
  localparam logic [2:0] c_wait  = 3'd2;
  localparam logic [2:0] c_pulse = 3'd3;
  localparam logic [2:0] c_done  = 3'd4;

  localparam logic [PER_W-1:0] c_min_t      = PER_W'(PULSE_CYCLES + 1);
  localparam logic [PER_W-1:0] c_pulse_last = PER_W'(PULSE_CYCLES - 1);
  localparam logic [PER_W-1:0] c_per_one    = PER_W'(1);
  localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_most_neg   = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] c_sat        = {1'b0, {(CNT_W-1){1'b1}}};

  logic [2:0]       r_state;
  logic [PER_W-1:0] r_cnt;
  logic [PER_W-1:0] r_t_m1;
  logic [CNT_W-1:0] r_ax;
  logic [CNT_W-1:0] r_ay;
  logic [CNT_W-1:0] r_major;
  logic [CNT_W-1:0] r_minor;
  logic             r_x_major;
  logic [CNT_W:0]   r_acc;
  logic [CNT_W-1:0] r_steps_left;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;
  logic             r_step_x;
  logic             r_step_y;
  logic             r_dir_x;
  logic             r_dir_y;

  logic [PER_W-1:0] w_per_eff;
  logic [PER_W-1:0] w_t;
  logic             w_x_major;
  logic [CNT_W-1:0] w_major;
  logic [CNT_W-1:0] w_minor;
  logic [CNT_W:0]   w_acc_sum;
  logic             w_minor_hit;
  logic             w_fire;
  logic             w_fire_x;
  logic             w_fire_y;

  function automatic logic [CNT_W-1:0] f_abs_sat(input logic [CNT_W-1:0] v);
    if (v == c_most_neg)
      return c_sat;
    else if (v[CNT_W-1])
      return -v;
    else
      return v;
  endfunction

  // Pulse high time plus at least one low cycle bounds the interval from below.
  assign w_per_eff = (bus.period == '0) ? c_per_one : bus.period;
  assign w_t       = (w_per_eff > c_min_t) ? w_per_eff : c_min_t;

  assign w_x_major = (r_ax >= r_ay);
  assign w_major   = w_x_major ? r_ax : r_ay;
  assign w_minor   = w_x_major ? r_ay : r_ax;

  assign w_acc_sum   = r_acc + {1'b0, r_minor};
  assign w_minor_hit = (w_acc_sum >= {1'b0, r_major});

  assign w_fire   = (r_state == c_wait) && !bus.abort && (r_cnt == r_t_m1);
  assign w_fire_x = w_fire && (r_x_major || w_minor_hit);
  assign w_fire_y = w_fire && (!r_x_major || w_minor_hit);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= c_idle;
      r_cnt        <= '0;
      r_t_m1       <= '0;
      r_ax         <= '0;
      r_ay         <= '0;
      r_major      <= '0;
      r_minor      <= '0;
      r_x_major    <= 1'b0;
      r_acc        <= '0;
      r_steps_left <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_step_x     <= 1'b0;
      r_step_y     <= 1'b0;
      r_dir_x      <= 1'b0;
      r_dir_y      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_cnt  <= r_cnt + c_per_one;
      case (r_state)
        c_idle: begin
          if (bus.start && !bus.abort) begin
            r_state   <= c_load;
            r_busy    <= 1'b1;
            r_aborted <= 1'b0;
            r_dir_x   <= bus.dx[CNT_W-1];
            r_dir_y   <= bus.dy[CNT_W-1];
            r_ax      <= f_abs_sat(bus.dx);
            r_ay      <= f_abs_sat(bus.dy);
            r_t_m1    <= w_t - c_per_one;
            r_cnt     <= '0;
          end
        end
        c_load: begin
          if (bus.abort) begin
            r_aborted <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= c_done;
          end else begin
            r_major      <= w_major;
            r_minor      <= w_minor;
            r_x_major    <= w_x_major;
            r_acc        <= {1'b0, w_major} >> 1;
            r_steps_left <= w_major;
            if (w_major == '0) begin
              r_done  <= 1'b1;
              r_state <= c_done;
            end else begin
              r_state <= c_wait;
            end
          end
        end
        c_wait: begin
          if (bus.abort) begin
            r_aborted <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= c_done;
          end else if (w_fire) begin
            r_state      <= c_pulse;
            r_cnt        <= '0;
            r_step_x     <= w_fire_x;
            r_step_y     <= w_fire_y;
            r_acc        <= w_minor_hit ? (w_acc_sum - {1'b0, r_major}) : w_acc_sum;
            r_steps_left <= r_steps_left - c_one;
          end
        end
        c_pulse: begin
          // The interval counter keeps running through the pulse so rises stay T apart.
          if (bus.abort) begin
            r_step_x  <= 1'b0;
            r_step_y  <= 1'b0;
            r_aborted <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= c_done;
          end else if (r_cnt == c_pulse_last) begin
            r_step_x <= 1'b0;
            r_step_y <= 1'b0;
            if (r_steps_left == '0) begin
              r_done  <= 1'b1;
              r_state <= c_done;
            end else begin
              r_state <= c_wait;
            end
          end
        end
        c_done: begin
          r_busy  <= 1'b0;
          r_state <= c_idle;
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

`ifdef STEP_POS_TRACK_EN
  logic [CNT_W-1:0] r_pos_x;
  logic [CNT_W-1:0] r_pos_y;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pos_x <= '0;
      r_pos_y <= '0;
    end else begin
      if (w_fire_x)
        r_pos_x <= r_dir_x ? (r_pos_x - c_one) : (r_pos_x + c_one);
      if (w_fire_y)
        r_pos_y <= r_dir_y ? (r_pos_y - c_one) : (r_pos_y + c_one);
    end
  end

  assign bus.pos_x = r_pos_x;
  assign bus.pos_y = r_pos_y;
`else
  assign bus.pos_x = '0;
  assign bus.pos_y = '0;
`endif

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.aborted    = r_aborted;
  assign bus.step_x     = r_step_x;
  assign bus.step_y     = r_step_y;
  assign bus.dir_x      = r_dir_x;
  assign bus.dir_y      = r_dir_y;
  assign bus.steps_left = r_steps_left;

endmodule
`default_nettype wire
